clk_run_ctrl: RTL



---
 rtl/clk_run_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/clk_run_ctrl.sv
// Run controller: sequences core reset release, gates the core clock enable
// (free-run / single-step / pause), and stops on HLT, error or cycle budget.
// Ports: CLK, reset (async active-low), run_req, step_req, halt_req, cpu_halt,
//        cpu_err -> core_rst_n, core_ce, state, cycle_cnt, done, stop_code.
module clk_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             cpu_halt,
  input  logic             cpu_err,
  output logic             core_rst_n,
  output logic             core_ce,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic [1:0]       stop_code
);

  localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_STOP = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [1:0]       code_q, code_d;
  logic             ce;
  logic             budget_hit;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    code_d    = code_q;
    ce         = (state_q == S_RUN) || (state_q == S_STEP);
    budget_hit = ce && (cnt_q == CNT_LAST);
    // The budget stops the core at MAX_CYCLES, so this never wraps.
    if (ce) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      S_RST: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (run_req && !halt_req) state_d = S_RUN;
        else if (step_req)        state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        priority case (1'b1)
          cpu_err: begin
            state_d = S_STOP;
            done_d  = 1'b1;
            code_d  = 2'd2;
          end
          cpu_halt: begin
            state_d = S_STOP;
            done_d  = 1'b1;
            code_d  = 2'd1;
          end
          budget_hit: begin
            state_d = S_STOP;
            done_d  = 1'b1;
            code_d  = 2'd3;
          end
          default: begin
            // A step is always a single enabled cycle.
            if (state_q == S_STEP || halt_req || !run_req)
              state_d = S_IDLE;
          end
        endcase
      end
      S_STOP: ;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      code_q    <= code_d;
    end
  end

  assign state      = state_q;
  assign core_ce    = ce;
  assign core_rst_n = (state_q != S_RST);
  assign cycle_cnt  = cnt_q;
  assign done       = done_q;
  assign stop_code  = code_q;

endmodule
